// File: rtl/weight_fetch_sequencer_if.sv
// Weight fetch bus: start request in, ROM address out, and the weight
// sideband (valid, indices, first/last) plus status toward the MAC datapath.
// Widths are derived from the layer shape so the sequencer and its consumer agree.
interface weight_fetch_sequencer_if #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10
) ();

  localparam int TOTAL      = NUM_INPUTS * NUM_NEURONS;
  localparam int ADDR_WIDTH = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int IN_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int NEU_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                  start;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  weight_valid;
  logic [IN_WIDTH-1:0]   input_index;
  logic [NEU_WIDTH-1:0]  neuron_index;
  logic                  first;
  logic                  last;
  logic                  busy;
  logic                  done;

  // Sequencer side: takes start, drives the ROM address and weight sideband.
  modport master (
    input  start,
    output rom_address, weight_valid, input_index, neuron_index,
    output first, last, busy, done
  );

  // Consumer side: requests a pass and receives the weight stream.
  modport slave (
    output start,
    input  rom_address, weight_valid, input_index, neuron_index,
    input  first, last, busy, done
  );

endinterface

// File: rtl/weight_fetch_sequencer.sv
// Walks a neuron-major weight ROM (address = neuron*NUM_INPUTS + input) once
// per start pulse. The ROM registers its output, so the weight sideband is
// registered one cycle behind the address and lines up with the ROM data.
// IDLE -> RUN (one address per cycle) -> FLUSH (final weight) -> IDLE + done.
module weight_fetch_sequencer #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10
) (
  input logic                      clock,
  input logic                      reset,
  weight_fetch_sequencer_if.master bus
);

  localparam int TOTAL      = NUM_INPUTS * NUM_NEURONS;
  localparam int ADDR_WIDTH = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int IN_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int NEU_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [IN_WIDTH-1:0]   IN_ONE   = IN_WIDTH'(1);
  localparam logic [NEU_WIDTH-1:0]  NEU_ONE  = NEU_WIDTH'(1);
  localparam logic [IN_WIDTH-1:0]   IN_LAST  = IN_WIDTH'(NUM_INPUTS - 1);
  localparam logic [NEU_WIDTH-1:0]  NEU_LAST = NEU_WIDTH'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                state_r;
  logic [IN_WIDTH-1:0]   in_cnt_r;
  logic [NEU_WIDTH-1:0]  neu_cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  valid_r;
  logic [IN_WIDTH-1:0]   in_idx_r;
  logic [NEU_WIDTH-1:0]  neu_idx_r;
  logic                  first_r;
  logic                  last_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  in_wrap_s;
  logic                  pass_end_s;

  // Terminal-count decodes of the counters that address the current weight.
  assign in_wrap_s  = (in_cnt_r == IN_LAST);
  assign pass_end_s = in_wrap_s && (neu_cnt_r == NEU_LAST);

  // Sequencer FSM: address counters in RUN, sideband lagging the address by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      in_cnt_r  <= '0;
      neu_cnt_r <= '0;
      addr_r    <= '0;
      valid_r   <= 1'b0;
      in_idx_r  <= '0;
      neu_idx_r <= '0;
      first_r   <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // ROM sits on address 0; a start launches a fresh pass from 0.
          in_cnt_r  <= '0;
          neu_cnt_r <= '0;
          addr_r    <= '0;
          valid_r   <= 1'b0;
          in_idx_r  <= '0;
          neu_idx_r <= '0;
          first_r   <= 1'b0;
          last_r    <= 1'b0;
          done_r    <= 1'b0;
          if (bus.start) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        ST_RUN: begin
          // The address issued this cycle becomes valid ROM data next cycle,
          // so its sideband is captured from the same counters now.
          valid_r   <= 1'b1;
          in_idx_r  <= in_cnt_r;
          neu_idx_r <= neu_cnt_r;
          first_r   <= (in_cnt_r == '0);
          last_r    <= in_wrap_s;
          busy_r    <= 1'b1;
          done_r    <= 1'b0;
          if (pass_end_s) begin
            state_r   <= ST_FLUSH;
            addr_r    <= '0;
            in_cnt_r  <= '0;
            neu_cnt_r <= '0;
          end else begin
            state_r <= ST_RUN;
            addr_r  <= addr_r + ADDR_ONE;
            if (in_wrap_s) begin
              in_cnt_r  <= '0;
              neu_cnt_r <= neu_cnt_r + NEU_ONE;
            end else begin
              in_cnt_r  <= in_cnt_r + IN_ONE;
              neu_cnt_r <= neu_cnt_r;
            end
          end
        end

        ST_FLUSH: begin
          // Final weight is on the ROM output during FLUSH; announce completion next.
          state_r   <= ST_IDLE;
          in_cnt_r  <= '0;
          neu_cnt_r <= '0;
          addr_r    <= '0;
          valid_r   <= 1'b0;
          in_idx_r  <= '0;
          neu_idx_r <= '0;
          first_r   <= 1'b0;
          last_r    <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
        end

        default: begin
          state_r   <= ST_IDLE;
          in_cnt_r  <= '0;
          neu_cnt_r <= '0;
          addr_r    <= '0;
          valid_r   <= 1'b0;
          in_idx_r  <= '0;
          neu_idx_r <= '0;
          first_r   <= 1'b0;
          last_r    <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_address  = addr_r;
  assign bus.weight_valid = valid_r;
  assign bus.input_index  = in_idx_r;
  assign bus.neuron_index = neu_idx_r;
  assign bus.first        = first_r;
  assign bus.last         = last_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench for weight_fetch_sequencer: cycle tables for a 3x2 and a 1x4
// layer, hand sequences for held start and mid-pass reset, and a full 784x10
// pass feeding a ROM model (w[k]=k) into a per-neuron accumulator.
module tb_weight_fetch_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  weight_fetch_sequencer_if #(.NUM_INPUTS(3),   .NUM_NEURONS(2))  bus_a ();
  weight_fetch_sequencer_if #(.NUM_INPUTS(1),   .NUM_NEURONS(4))  bus_b ();
  weight_fetch_sequencer_if #(.NUM_INPUTS(784), .NUM_NEURONS(10)) bus_c ();

  weight_fetch_sequencer #(.NUM_INPUTS(3),   .NUM_NEURONS(2))  dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  weight_fetch_sequencer #(.NUM_INPUTS(1),   .NUM_NEURONS(4))  dut_b (.clock(clock), .reset(reset), .bus(bus_b));
  weight_fetch_sequencer #(.NUM_INPUTS(784), .NUM_NEURONS(10)) dut_c (.clock(clock), .reset(reset), .bus(bus_c));

  // ROM model with registered read, contents w[k] = k.
  logic [31:0] rom_q;
  always @(posedge clock) rom_q <= 32'(bus_c.rom_address);

  typedef struct {
    logic       start;
    logic       addr_care;
    logic [3:0] addr;
    logic       valid;
    logic [3:0] n;
    logic [3:0] i;
    logic       first;
    logic       last;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tab_a [17];
  vec_t tab_b [7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic cmp_row(input string tag, input int idx, input vec_t v,
                         input logic [31:0] addr, input logic valid,
                         input logic [31:0] n, input logic [31:0] i,
                         input logic first, input logic last,
                         input logic busy, input logic done);
    if (v.addr_care) check($sformatf("%s[%0d].rom_address", tag, idx), addr, 32'(v.addr));
    check($sformatf("%s[%0d].weight_valid", tag, idx), 32'(valid), 32'(v.valid));
    check($sformatf("%s[%0d].neuron_index", tag, idx), n, 32'(v.n));
    check($sformatf("%s[%0d].input_index", tag, idx), i, 32'(v.i));
    check($sformatf("%s[%0d].first", tag, idx), 32'(first), 32'(v.first));
    check($sformatf("%s[%0d].last", tag, idx), 32'(last), 32'(v.last));
    check($sformatf("%s[%0d].busy", tag, idx), 32'(busy), 32'(v.busy));
    check($sformatf("%s[%0d].done", tag, idx), 32'(done), 32'(v.done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          phase;
    int          cnt;
    int          nvalid;
    int          first_cyc;
    int          last_cyc;
    logic        got_done;
    logic [31:0] acc;
    logic [31:0] sums [10];

    // Fields: start, addr_care, addr, valid, n, i, first, last, busy, done.
    // 3x2 layer: pass with ignored starts while busy, restart in the done cycle.
    tab_a[0]  = '{1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab_a[1]  = '{1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab_a[2]  = '{1'b0, 1'b1, 4'd2, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab_a[3]  = '{1'b1, 1'b1, 4'd3, 1'b1, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    tab_a[4]  = '{1'b0, 1'b1, 4'd4, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab_a[5]  = '{1'b0, 1'b1, 4'd5, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab_a[6]  = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    tab_a[7]  = '{1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tab_a[8]  = '{1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab_a[9]  = '{1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab_a[10] = '{1'b0, 1'b1, 4'd2, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab_a[11] = '{1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    tab_a[12] = '{1'b0, 1'b1, 4'd4, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab_a[13] = '{1'b0, 1'b1, 4'd5, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab_a[14] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    tab_a[15] = '{1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tab_a[16] = '{1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // 1x4 layer: every weight is both first and last of its neuron.
    tab_b[0] = '{1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab_b[1] = '{1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tab_b[2] = '{1'b0, 1'b1, 4'd2, 1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tab_b[3] = '{1'b0, 1'b1, 4'd3, 1'b1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tab_b[4] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tab_b[5] = '{1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tab_b[6] = '{1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;

    // Power-up reset, asserted between clock edges.
    #1 reset = 1'b1;
    #2;
    check("reset.rom_address", 32'(bus_a.rom_address), 32'd0);
    check("reset.weight_valid", 32'(bus_a.weight_valid), 32'd0);
    check("reset.busy", 32'(bus_a.busy), 32'd0);
    check("reset.done", 32'(bus_a.done), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 3x2 cycle table.
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      bus_a.start = tab_a[k].start;
      @(posedge clock);
      #1;
      cmp_row("t3x2", k, tab_a[k], 32'(bus_a.rom_address), bus_a.weight_valid,
              32'(bus_a.neuron_index), 32'(bus_a.input_index), bus_a.first,
              bus_a.last, bus_a.busy, bus_a.done);
    end

    // Start held high: passes repeat every N*M+2 cycles. Cycle 0 is the
    // accepting edge, 1..6 carry weights, 7 is the done cycle (restart),
    // and the next cycle 0 is address 0 of the following pass.
    @(negedge clock);
    bus_a.start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(posedge clock);
      #1;
      phase = c % 8;
      check($sformatf("held[%0d].weight_valid", c), 32'(bus_a.weight_valid),
            (phase >= 1 && phase <= 6) ? 32'd1 : 32'd0);
      check($sformatf("held[%0d].done", c), 32'(bus_a.done), (phase == 7) ? 32'd1 : 32'd0);
      check($sformatf("held[%0d].busy", c), 32'(bus_a.busy), (phase == 7) ? 32'd0 : 32'd1);
      if (phase >= 1 && phase <= 6) begin
        check($sformatf("held[%0d].neuron_index", c), 32'(bus_a.neuron_index), 32'((phase - 1) / 3));
        check($sformatf("held[%0d].input_index", c), 32'(bus_a.input_index), 32'((phase - 1) % 3));
      end
    end
    @(negedge clock);
    bus_a.start = 1'b0;
    repeat (2) @(negedge clock);

    // Reset asserted while the 3rd weight is on the bus, then a fresh start.
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("midrst.pre.weight_valid", 32'(bus_a.weight_valid), 32'd1);
    check("midrst.pre.input_index", 32'(bus_a.input_index), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("midrst.rom_address", 32'(bus_a.rom_address), 32'd0);
    check("midrst.weight_valid", 32'(bus_a.weight_valid), 32'd0);
    check("midrst.neuron_index", 32'(bus_a.neuron_index), 32'd0);
    check("midrst.input_index", 32'(bus_a.input_index), 32'd0);
    check("midrst.first", 32'(bus_a.first), 32'd0);
    check("midrst.last", 32'(bus_a.last), 32'd0);
    check("midrst.busy", 32'(bus_a.busy), 32'd0);
    check("midrst.done", 32'(bus_a.done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      if (bus_a.done || bus_a.weight_valid) cnt++;
    end
    check("midrst.no_done_or_valid", 32'(cnt), 32'd0);
    @(negedge clock);
    bus_a.start = 1'b1;
    @(posedge clock);
    #1;
    check("midrst.restart.rom_address", 32'(bus_a.rom_address), 32'd0);
    check("midrst.restart.busy", 32'(bus_a.busy), 32'd1);
    @(negedge clock);
    bus_a.start = 1'b0;
    @(posedge clock);
    #1;
    check("midrst.restart.weight_valid", 32'(bus_a.weight_valid), 32'd1);
    check("midrst.restart.neuron_index", 32'(bus_a.neuron_index), 32'd0);
    check("midrst.restart.input_index", 32'(bus_a.input_index), 32'd0);
    check("midrst.restart.first", 32'(bus_a.first), 32'd1);
    check("midrst.restart.rom_address", 32'(bus_a.rom_address), 32'd1);

    // 1x4 cycle table.
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      bus_b.start = tab_b[k].start;
      @(posedge clock);
      #1;
      cmp_row("t1x4", k, tab_b[k], 32'(bus_b.rom_address), bus_b.weight_valid,
              32'(bus_b.neuron_index), 32'(bus_b.input_index), bus_b.first,
              bus_b.last, bus_b.busy, bus_b.done);
    end

    // Full 784x10 pass through the ROM model into a per-neuron accumulator.
    for (int n = 0; n < 10; n++) sums[n] = 32'd0;
    acc       = 32'd0;
    nvalid    = 0;
    first_cyc = -1;
    last_cyc  = -1;
    got_done  = 1'b0;
    cyc       = 0;
    @(negedge clock);
    bus_c.start = 1'b1;
    @(posedge clock);
    while (!got_done && cyc < 9000) begin
      @(negedge clock);
      bus_c.start = 1'b0;
      @(posedge clock);
      cyc++;
      #1;
      if (bus_c.weight_valid) begin
        nvalid++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (bus_c.first) acc = rom_q;
        else acc = acc + rom_q;
        if (bus_c.last && bus_c.neuron_index < 4'd10) sums[bus_c.neuron_index] = acc;
      end
      if (bus_c.done) got_done = 1'b1;
    end
    check("full.done_seen", 32'(got_done), 32'd1);
    check("full.done_latency", 32'(cyc), 32'd7841);
    check("full.valid_count", 32'(nvalid), 32'd7840);
    check("full.first_valid_cycle", 32'(first_cyc), 32'd1);
    check("full.valid_span", 32'(last_cyc - first_cyc + 1), 32'd7840);
    for (int n = 0; n < 10; n++) begin
      check($sformatf("full.sum[%0d]", n), sums[n], 32'(614656 * n + 306936));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
